// File: rtl/register_file_pkg.sv
// Shared constants for the RV32I integer register file.
//   DefDataWidth    : default register / data-port width (32)
//   DefAddressWidth : default register index width (5)
//   NumRegs         : register count for the default index width (32)
//   ZeroReg         : index of the hardwired-zero register x0
package register_file_pkg;

  localparam int unsigned DefDataWidth    = 32;
  localparam int unsigned DefAddressWidth = 5;
  localparam int unsigned NumRegs         = 2 ** DefAddressWidth;
  localparam logic [DefAddressWidth-1:0] ZeroReg = 5'd0;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// RV32I integer register file: 2**AddressWidth registers of DataWidth bits,
// two combinational read ports and one synchronous write port. x0 reads as 0
// and ignores writes.
// Ports:
//   clk             : clock, writes commit on the rising edge
//   rst             : asynchronous active-high reset, clears every register
//   rs1 / rs2       : read indices
//   rs1_data_out    : contents of register rs1 (combinational, no bypass)
//   rs2_data_out    : contents of register rs2 (combinational, no bypass)
//   rd              : write index
//   rd_write_enable : commit rd_data_in to register rd on the next edge
//   rd_data_in      : write data
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DataWidth    = DefDataWidth,
  parameter int unsigned AddressWidth = DefAddressWidth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AddressWidth-1:0] rs1,
  output logic [DataWidth-1:0]    rs1_data_out,
  input  logic [AddressWidth-1:0] rs2,
  output logic [DataWidth-1:0]    rs2_data_out,
  input  logic [AddressWidth-1:0] rd,
  input  logic                    rd_write_enable,
  input  logic [DataWidth-1:0]    rd_data_in
);

  localparam int unsigned RegCount = 2 ** AddressWidth;
  localparam logic [AddressWidth-1:0] ZeroIdx = AddressWidth'(ZeroReg);

  logic [DataWidth-1:0] regs_q [RegCount];
  logic [DataWidth-1:0] regs_d [RegCount];

  // Next state: at most one register changes per edge; x0 is never written,
  // so its entry holds the reset value of zero forever.
  always_comb begin
    regs_d = regs_q;
    if (rd_write_enable && (rd != ZeroIdx)) begin
      regs_d[rd] = rd_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RegCount); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from the flops: during a write cycle they still show
  // the old value, and the new one appears right after the edge.
  always_comb begin
    rs1_data_out = (rs1 == ZeroIdx) ? '0 : regs_q[rs1];
    rs2_data_out = (rs2 == ZeroIdx) ? '0 : regs_q[rs2];
  end

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rs1 = '0;
  logic [AW-1:0] rs2 = '0;
  logic [AW-1:0] rd  = '0;
  logic          rd_write_enable = 1'b0;
  logic [DW-1:0] rd_data_in = '0;
  logic [DW-1:0] rs1_data_out;
  logic [DW-1:0] rs2_data_out;

  int vectors = 0;
  int miscompares = 0;

  register_file #(.DataWidth(DW), .AddressWidth(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .rs1             (rs1),
    .rs1_data_out    (rs1_data_out),
    .rs2             (rs2),
    .rs2_data_out    (rs2_data_out),
    .rd              (rd),
    .rd_write_enable (rd_write_enable),
    .rd_data_in      (rd_data_in)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [AW-1:0] idx, input logic [DW-1:0] val);
    rd = idx;
    rd_data_in = val;
    rd_write_enable = 1'b1;
    tick();
    rd_write_enable = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp_v;

    // Reset state
    rs1 = 5'd5;
    rs2 = 5'd31;
    #2;
    check("reset_rs1", rs1_data_out, 32'h0);
    check("reset_rs2", rs2_data_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_reset_x5", rs1_data_out, 32'h0);

    // Asynchronous reset clear mid-cycle
    write_reg(5'd5, 32'hDEADBEEF);
    rs1 = 5'd5;
    #1;
    check("x5_written", rs1_data_out, 32'hDEADBEEF);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_high", rs1_data_out, 32'h0);
    rst = 1'b0;
    #1;
    check("async_rst_released", rs1_data_out, 32'h0);
    tick();
    check("async_rst_after_edge", rs1_data_out, 32'h0);

    // Enable gating
    rd = 5'd7;
    rd_data_in = 32'h12345678;
    rd_write_enable = 1'b0;
    rs1 = 5'd7;
    tick();
    check("we0_x7_unchanged", rs1_data_out, 32'h0);
    rd_write_enable = 1'b1;
    tick();
    rd_write_enable = 1'b0;
    check("we1_x7_written", rs1_data_out, 32'h12345678);

    // x0 protection
    write_reg(5'd0, 32'hFFFFFFFF);
    rs1 = 5'd0;
    rs2 = 5'd0;
    #1;
    check("x0_rs1", rs1_data_out, 32'h0);
    check("x0_rs2", rs2_data_out, 32'h0);

    // Write all, then sweep both ports in opposite directions
    for (int i = 1; i < 32; i++) write_reg(AW'(i), 32'h1000_0000 + i);
    for (int i = 0; i < 32; i++) begin
      rs1 = AW'(i);
      rs2 = AW'(31 - i);
      #1;
      exp_v = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
      check("sweep_rs1", rs1_data_out, exp_v);
      exp_v = (i == 31) ? 32'h0 : 32'h1000_0000 + (31 - i);
      check("sweep_rs2", rs2_data_out, exp_v);
    end

    // Read during write, same index on both ports
    write_reg(5'd3, 32'h11111111);
    rd = 5'd3;
    rd_data_in = 32'h22222222;
    rd_write_enable = 1'b1;
    rs1 = 5'd3;
    rs2 = 5'd3;
    #1;
    check("rdw_before_rs1", rs1_data_out, 32'h11111111);
    check("rdw_before_rs2", rs2_data_out, 32'h11111111);
    tick();
    rd_write_enable = 1'b0;
    check("rdw_after_rs1", rs1_data_out, 32'h22222222);
    check("rdw_after_rs2", rs2_data_out, 32'h22222222);

    // Combinational read latency, no clock edge between address changes
    write_reg(5'd9, 32'hA5A5A5A5);
    write_reg(5'd10, 32'h5A5A5A5A);
    rs1 = 5'd9;
    #1;
    check("comb_x9", rs1_data_out, 32'hA5A5A5A5);
    rs1 = 5'd10;
    #1;
    check("comb_x10", rs1_data_out, 32'h5A5A5A5A);

    // Back-to-back writes: same register last wins, different registers both commit
    write_reg(5'd12, 32'hAAAA0001);
    write_reg(5'd12, 32'hBBBB0002);
    write_reg(5'd13, 32'hCCCC0003);
    rs1 = 5'd12;
    rs2 = 5'd13;
    #1;
    check("b2b_last_wins", rs1_data_out, 32'hBBBB0002);
    check("b2b_other_reg", rs2_data_out, 32'hCCCC0003);

    // Reset overrides a write pending at the edge
    rd = 5'd14;
    rd_data_in = 32'hFEEDFACE;
    rd_write_enable = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_write_enable = 1'b0;
    rs1 = 5'd14;
    rs2 = 5'd12;
    #1;
    check("rst_blocks_write", rs1_data_out, 32'h0);
    check("rst_clears_x12", rs2_data_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_register_file
